// File: rtl/shiftleft_pipe.sv
// Two-stage pipelined 64-bit logical left shifter with RV64 SLL/SLLW semantics.
// Stage A shifts by the fine amount (1/2/4), stage B by the coarse amount (8/16/32).
module shiftleft_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [5:0]       in_shamt,
  input  logic             in_word,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic             a_valid_q, a_valid_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic [2:0]       a_rem_q, a_rem_d;
  logic             a_word_q, a_word_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d;

  logic             b_valid_q, b_valid_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;
  logic [TAG_W-1:0] b_tag_q, b_tag_d;

  logic             a_load, b_load;
  logic [WIDTH-1:0] b_shift;

  // Backpressure chain: B frees a slot when empty or draining, A follows B.
  assign b_load   = !b_valid_q || out_ready;
  assign a_load   = !a_valid_q || b_load;
  assign in_ready = a_load;

  assign b_shift = a_data_q << {a_rem_q, 3'b000};

  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    a_rem_d   = a_rem_q;
    a_word_d  = a_word_q;
    a_tag_d   = a_tag_q;
    if (a_load) begin
      a_valid_d = in_valid;
      if (in_valid) begin
        a_data_d = in_data << in_shamt[2:0];
        // Word mode ignores shamt[5]; only 8/16 remain for stage B.
        a_rem_d  = in_word ? {1'b0, in_shamt[4:3]} : in_shamt[5:3];
        a_word_d = in_word;
        a_tag_d  = in_tag;
      end
    end
  end

  always_comb begin
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    b_tag_d   = b_tag_q;
    if (b_load) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_data_d = a_word_q ? {{(WIDTH - 32){b_shift[31]}}, b_shift[31:0]} : b_shift;
        b_tag_d  = a_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_rem_q   <= '0;
      a_word_q  <= 1'b0;
      a_tag_q   <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_tag_q   <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      a_rem_q   <= a_rem_d;
      a_word_q  <= a_word_d;
      a_tag_q   <= a_tag_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_tag_q   <= b_tag_d;
    end
  end

  assign out_valid = b_valid_q;
  assign out_data  = b_data_q;
  assign out_tag   = b_tag_q;

endmodule

// File: tb/tb_shiftleft_pipe.sv
// Scoreboard bench for shiftleft_pipe: driver pushes expected results, monitor pops on output.
module tb_shiftleft_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [5:0]  in_shamt;
  logic        in_word;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_tag;

  int checks   = 0;
  int failures = 0;
  int received = 0;
  bit mon_en   = 1'b0;

  logic [63:0] exp_data_q[$];
  logic [4:0]  exp_tag_q[$];

  shiftleft_pipe #(.WIDTH(64), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_word   (in_word),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the shift rules, no stage split.
  function automatic logic [63:0] ref_sll(input logic [63:0] d, input int sh, input bit w);
    logic [31:0] lo;
    if (w) begin
      lo = d[31:0];
      lo = lo << (sh % 32);
      return {{32{lo[31]}}, lo};
    end
    return d << sh;
  endfunction

  task automatic send(input logic [63:0] d, input logic [5:0] sh, input logic w,
                      input logic [4:0] tg, input logic [63:0] exp);
    int waitc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_word  = w;
    in_tag   = tg;
    #1;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      exp_data_q.push_back(exp);
      exp_tag_q.push_back(tg);
    end
  endtask

  // Idle cycle with garbage on the data inputs; must be ignored.
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_shamt = 6'($urandom);
    in_word  = 1'($urandom);
    in_tag   = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_data_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining", 64'(exp_data_q.size()), 64'd0);
  endtask

  // Monitor: pops on every output transfer, and checks hold-stability while stalled.
  initial begin
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;
    logic [4:0]  prev_tag   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid_hold", 64'(out_valid), 64'd1);
          chk("stall_data_hold", out_data, prev_data);
          chk("stall_tag_hold", 64'(out_tag), 64'(prev_tag));
        end
        if (out_valid && out_ready) begin
          if (exp_data_q.size() == 0) begin
            chk("unexpected_output", 64'(out_tag), 64'hffff_ffff_ffff_ffff);
          end else begin
            chk("out_data", out_data, exp_data_q.pop_front());
            chk("out_tag", 64'(out_tag), 64'(exp_tag_q.pop_front()));
            received++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_tag   = out_tag;
      end
    end
  end

  initial begin
    logic [63:0] d;
    int          sh;
    bit          w;
    int          sent;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_word   = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    #22;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Latency of exactly two cycles, shift by 63.
    send(64'h1, 6'd63, 1'b0, 5'd3, 64'h8000_0000_0000_0000);
    idle();
    #2;
    chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    #2;
    chk("lat_cycle2_valid", 64'(out_valid), 64'd1);

    // Directed corner cases with literal expectations.
    send(64'h0000_0000_4000_0001, 6'd1, 1'b1, 5'd4, 64'hFFFF_FFFF_8000_0002);
    send(64'h0000_0000_4000_0001, 6'd33, 1'b1, 5'd5, 64'hFFFF_FFFF_8000_0002);
    send(64'hDEAD_BEEF_CAFE_F00D, 6'd0, 1'b0, 5'd6, 64'hDEAD_BEEF_CAFE_F00D);
    send(64'hDEAD_BEEF_CAFE_F00D, 6'd32, 1'b0, 5'd7, 64'hCAFE_F00D_0000_0000);
    send(64'hDEAD_BEEF_CAFE_F00D, 6'd0, 1'b1, 5'd8, 64'hFFFF_FFFF_CAFE_F00D);
    send(64'h1234_5678_0000_00FF, 6'd4, 1'b1, 5'd9, 64'h0000_0000_0000_0FF0);
    idle();
    drain();

    // Eight back-to-back ops with a five-cycle mid-stream stall.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          d = {32'hA5A5_0000 | 32'(i), 32'h8765_4321 + 32'(i)};
          send(d, 6'(i * 7), 1'(i), 5'(i), ref_sll(d, i * 7, 1'(i)));
        end
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          out_ready = 1'b0;
        end
        #1;
        chk("stall_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("b2b_received", 64'(received), 64'd15);

    // Randomized traffic against the reference model.
    sent = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          repeat ($urandom_range(0, 2)) idle();
          d  = {$urandom, $urandom};
          sh = int'($urandom_range(0, 63));
          w  = 1'($urandom);
          send(d, 6'(sh), w, 5'(i), ref_sll(d, sh, w));
          sent++;
        end
        idle();
      end
      begin
        while (sent < 10000) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    chk("rand_received", 64'(received), 64'd10015);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(64'h1111, 6'd1, 1'b0, 5'd20, 64'h2222);
    send(64'h2222, 6'd1, 1'b0, 5'd21, 64'h4444);
    idle();
    @(negedge clk);
    #1;
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_out_data", out_data, 64'd0);
    chk("async_rst_out_tag", 64'(out_tag), 64'd0);
    exp_data_q.delete();
    exp_tag_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    send(64'h0000_0000_0000_00F0, 6'd8, 1'b0, 5'd22, 64'h0000_0000_0000_F000);
    idle();
    #2;
    chk("post_rst_lat1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    #2;
    chk("post_rst_lat2_valid", 64'(out_valid), 64'd1);
    drain();
    @(negedge clk);
    #2;
    chk("final_idle_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
